de2_pio_blink_out: RTL and testbench
====================================

DE2_PIO_BLINK_OUT -- requirements
Module: de2_pio_blink_out

Interface
REQ-001 The block SHALL take parameter WIDTH, default 9, number of output bits (1..32).
REQ-002 The block SHALL take parameter RESET_VALUE, default 0, DATA register value after reset (WIDTH bits).
REQ-003 The block SHALL take parameter PERIOD_W, default 24, width of the PERIOD register and blink counter (1..32).
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 address  input  3  Avalon-MM slave word address.
REQ-007 chipselect  input  1  slave select.
REQ-008 write_n  input  1  active-low write strobe.
REQ-009 writedata  input  32  write data.
REQ-010 readdata  output  32  read data, zero-extended, zero read wait states.
REQ-011 out_port  output  WIDTH  pin drive to LEDs.

Function
REQ-012 A write SHALL occur on a rising clk edge where chipselect=1 and write_n=0; all other cycles SHALL leave registers unchanged except the blink counter/phase.
REQ-013 Register map: 0 DATA (rw, WIDTH bits); 1 BLINK_MASK (rw, WIDTH bits); 2 PERIOD (rw, PERIOD_W bits); 3 STATUS (ro, bit0=phase); 4 OUTSET (wo); 5 OUTCLEAR (wo); 6-7 reserved.
REQ-014 Write to DATA/BLINK_MASK/PERIOD SHALL load writedata[width-1:0]; upper writedata bits ignored.
REQ-015 Write to OUTSET SHALL perform DATA <= DATA | writedata[WIDTH-1:0]; write to OUTCLEAR SHALL perform DATA <= DATA & ~writedata[WIDTH-1:0].
REQ-016 Writes to STATUS and reserved addresses SHALL have no effect.
REQ-017 readdata SHALL be combinational from address and register state, zero-extended; OUTSET, OUTCLEAR and reserved addresses SHALL read 0; reads SHALL have no side effects.
REQ-018 Blink counter cnt (PERIOD_W bits) and phase (1 bit) SHALL update every cycle: PERIOD=0 -> cnt<=0, phase<=1; else cnt=PERIOD-1 -> cnt<=0, phase<=~phase; else cnt<=cnt+1.
REQ-019 A write to PERIOD SHALL, on the same edge, force cnt<=0 and phase<=1, overriding REQ-018.
REQ-020 Phase toggle rate SHALL be one toggle every PERIOD cycles (full blink period 2*PERIOD cycles); PERIOD=1 toggles every cycle.
REQ-021 out_port SHALL equal DATA & ~(BLINK_MASK & {WIDTH{~phase}}), combinational from registers only (no path from bus inputs).
REQ-022 Bits with BLINK_MASK=0 SHALL follow DATA with one-cycle latency from the write edge; masked bits with DATA=0 SHALL stay 0.
REQ-023 Write to DATA/OUTSET/OUTCLEAR SHALL NOT affect cnt or phase.

Reset
REQ-024 While reset_n=0: DATA=RESET_VALUE, BLINK_MASK=0, PERIOD=0, cnt=0, phase=1; out_port=RESET_VALUE; applies immediately, independent of clk, including mid-blink.
REQ-025 First write SHALL be accepted on the first rising clk edge after reset_n deasserts.

Verification
REQ-026 Reset: assert reset_n=0 mid-operation with DATA=0x1FF, mask=0x0F0 -> out_port=0x000 immediately, all reads 0 except STATUS=1.
REQ-027 Set/clear: write DATA=0x0A5, OUTSET 0x100, OUTCLEAR 0x005 -> DATA reads 0x1A0, out_port 0x1A0, OUTSET/OUTCLEAR read 0.
REQ-028 Blink: DATA=0x1FF, mask=0x003, PERIOD=4 -> out_port 0x1FF for 4 cycles after PERIOD write, then 0x1FC for 4, repeating; STATUS bit0 tracks phase.
REQ-029 Re-sync: rewrite PERIOD=4 at cnt=2, phase=0 -> next cycle phase=1, cnt=0, out_port masked bits restored.
REQ-030 Boundaries: PERIOD=1 -> masked bits toggle every cycle; PERIOD=0 -> masked bits steady at DATA; writedata=0xFFFFFFFF to DATA -> reads 0x1FF.

Source files
------------

// File: rtl/de2_pio_blink_out.sv
// Avalon-MM LED output PIO with atomic set/clear and a programmable blink mask.
// Masked bits are forced low during the off half of each blink period.
module de2_pio_blink_out #(
  parameter int unsigned            WIDTH       = 9,
  parameter logic [WIDTH-1:0]       RESET_VALUE = '0,
  parameter int unsigned            PERIOD_W    = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [2:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic [WIDTH-1:0]    out_port
);

  typedef enum logic [2:0] {
    REG_DATA     = 3'd0,
    REG_MASK     = 3'd1,
    REG_PERIOD   = 3'd2,
    REG_STATUS   = 3'd3,
    REG_OUTSET   = 3'd4,
    REG_OUTCLEAR = 3'd5
  } reg_addr_t;

  localparam logic [PERIOD_W-1:0] CNT_ONE = PERIOD_W'(1);

  logic [WIDTH-1:0]    data;
  logic [WIDTH-1:0]    blink_mask;
  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] cnt;
  logic                phase;

  logic                wr;
  logic [WIDTH-1:0]    wr_bits;
  reg_addr_t           reg_sel;

  assign wr      = chipselect & ~write_n;
  assign wr_bits = writedata[WIDTH-1:0];
  assign reg_sel = reg_addr_t'(address);

  // Bus-writable registers; STATUS and reserved addresses ignore writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data       <= RESET_VALUE;
      blink_mask <= '0;
      period     <= '0;
    end else if (wr) begin
      case (reg_sel)
        REG_DATA:     data       <= wr_bits;
        REG_MASK:     blink_mask <= wr_bits;
        REG_PERIOD:   period     <= writedata[PERIOD_W-1:0];
        REG_OUTSET:   data       <= data | wr_bits;
        REG_OUTCLEAR: data       <= data & ~wr_bits;
        default:      ;
      endcase
    end
  end

  // Blink timebase; a PERIOD write restarts the on-phase from the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if ((wr && reg_sel == REG_PERIOD) || period == '0) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (cnt == period - CNT_ONE) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + CNT_ONE;
    end
  end

  // Zero-wait-state read mux; write-only and reserved addresses read as zero.
  always_comb begin
    readdata = '0;
    case (reg_sel)
      REG_DATA:   readdata = 32'(data);
      REG_MASK:   readdata = 32'(blink_mask);
      REG_PERIOD: readdata = 32'(period);
      REG_STATUS: readdata = 32'(phase);
      default:    readdata = '0;
    endcase
  end

  // Pin drive depends on registers only, never on the bus inputs.
  always_comb begin
    out_port = data & ~(blink_mask & {WIDTH{~phase}});
  end

endmodule

// File: tb/tb_de2_pio_blink_out.sv
// Scoreboard bench for de2_pio_blink_out: a driver pushes expected read/pin
// values from a cycle-count reference model; a monitor pops and compares.
module tb_de2_pio_blink_out;

  localparam int unsigned WIDTH    = 9;
  localparam int unsigned PERIOD_W = 24;
  localparam logic [31:0] WMASK    = 32'h0000_01FF;
  localparam logic [31:0] PMASK    = 32'h00FF_FFFF;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [2:0]       address = 3'd0;
  logic             chipselect = 1'b0;
  logic             write_n = 1'b1;
  logic [31:0]      writedata = '0;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] out_port;

  de2_pio_blink_out #(
    .WIDTH(WIDTH),
    .RESET_VALUE(9'h000),
    .PERIOD_W(PERIOD_W)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .out_port(out_port)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic [31:0] op;
  } exp_t;
  exp_t sb[$];

  // Reference model: registers plus number of edges since the last resync.
  logic [31:0]     m_data, m_mask, m_period;
  longint unsigned m_k;

  function automatic logic m_phase();
    if (m_period == 0) return 1'b1;
    return ((m_k / m_period) % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  function automatic logic [31:0] m_out();
    return m_phase() ? m_data : (m_data & ~m_mask);
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0:    return m_data;
      3'd1:    return m_mask;
      3'd2:    return m_period;
      3'd3:    return {31'b0, m_phase()};
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_reset();
    m_data = 32'h0; m_mask = 32'h0; m_period = 32'h0; m_k = 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a falling edge; drives one bus cycle and returns at the next falling edge.
  task automatic cycle(input string name, input bit cs, input bit wr,
                       input logic [2:0] a, input logic [31:0] wd);
    exp_t e;
    bit   resync;
    chipselect = cs; write_n = ~wr; address = a; writedata = wd;
    e.name = name; e.rd = m_read(a); e.op = m_out();
    sb.push_back(e);
    resync = (cs && wr && a == 3'd2) || (m_period == 0);
    if (cs && wr) begin
      case (a)
        3'd0: m_data   = wd & WMASK;
        3'd1: m_mask   = wd & WMASK;
        3'd2: m_period = wd & PMASK;
        3'd4: m_data   = m_data | (wd & WMASK);
        3'd5: m_data   = m_data & ~(wd & WMASK);
        default: ;
      endcase
    end
    m_k = resync ? 0 : m_k + 1;
    @(negedge clk);
  endtask

  task automatic wr_reg(input string name, input logic [2:0] a, input logic [31:0] wd);
    cycle(name, 1'b1, 1'b1, a, wd);
  endtask

  task automatic rd_reg(input string name, input logic [2:0] a);
    cycle(name, 1'b1, 1'b0, a, $urandom);
  endtask

  task automatic reset_reads(input string name);
    for (int i = 0; i < 8; i++) begin
      address = 3'(i);
      #1;
      check($sformatf("%s read[%0d]", name, i), readdata, (i == 3) ? 32'h1 : 32'h0);
    end
  endtask

  // Monitor: each driven cycle presents one read/pin sample just after the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.name, " readdata"}, readdata, e.rd);
        check({e.name, " out_port"}, {23'b0, out_port}, e.op);
      end
    end
  end

  initial begin
    m_reset();
    repeat (2) @(negedge clk);
    #1;
    check("reset out_port", {23'b0, out_port}, 32'h0);
    reset_reads("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // First edge after reset accepts a write; then set/clear
    wr_reg("w data",   3'd0, 32'h0000_00A5);
    wr_reg("outset",   3'd4, 32'h0000_0100);
    wr_reg("outclear", 3'd5, 32'h0000_0005);
    rd_reg("rd data",  3'd0);
    rd_reg("rd outset", 3'd4);
    rd_reg("rd outclr", 3'd5);
    rd_reg("rd rsvd6", 3'd6);
    wr_reg("w status", 3'd3, 32'hFFFF_FFFF);
    rd_reg("rd status", 3'd3);

    // Upper writedata bits ignored
    wr_reg("w data ff", 3'd0, 32'hFFFF_FFFF);
    rd_reg("rd data ff", 3'd0);

    // Blink with PERIOD=4
    wr_reg("w mask", 3'd1, 32'h0000_0003);
    wr_reg("w period4", 3'd2, 32'h0000_0004);
    for (int i = 0; i < 6; i++) rd_reg("blink", 3'd3);
    // Now at cnt=2, phase=0: rewrite PERIOD to resync
    wr_reg("resync", 3'd2, 32'hAB00_0004);
    for (int i = 0; i < 10; i++) rd_reg("post resync", 3'd3);

    // PERIOD=1 toggles every cycle, PERIOD=0 holds phase high
    wr_reg("w period1", 3'd2, 32'h0000_0001);
    for (int i = 0; i < 6; i++) rd_reg("period1", 3'd3);
    wr_reg("w period0", 3'd2, 32'h0000_0000);
    for (int i = 0; i < 4; i++) rd_reg("period0", 3'd2);

    // Randomized bus traffic
    for (int i = 0; i < 400; i++) begin
      logic [2:0]  a;
      logic [31:0] wd;
      a  = 3'($urandom_range(0, 7));
      wd = $urandom;
      if (a == 3'd2) wd = (wd & 32'hFF00_0000) | 32'($urandom_range(0, 6));
      cycle("random", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a, wd);
    end

    // Asynchronous reset in the middle of blinking
    wr_reg("pre-rst data", 3'd0, 32'h0000_01FF);
    wr_reg("pre-rst mask", 3'd1, 32'h0000_00F0);
    wr_reg("pre-rst per",  3'd2, 32'h0000_0003);
    for (int i = 0; i < 4; i++) rd_reg("pre-rst", 3'd3);
    chipselect = 1'b0; write_n = 1'b1;
    #3;
    reset_n = 1'b0;
    m_reset();
    #1;
    check("mid reset out_port", {23'b0, out_port}, 32'h0);
    reset_reads("mid reset");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    wr_reg("post-rst data", 3'd0, 32'h0000_0155);
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  a;
      logic [31:0] wd;
      a  = 3'($urandom_range(0, 5));
      wd = $urandom;
      if (a == 3'd2) wd = 32'($urandom_range(0, 3));
      cycle("post-rst random", 1'b1, 1'($urandom_range(0, 1)), a, wd);
    end

    chipselect = 1'b0; write_n = 1'b1;
    #5;
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
